// File: rtl/freq_divider_mc.sv
// -----------------------------------------------------------------------------
// freq_divider_mc
//   Multi-channel programmable clock divider. Every channel divides clk by its
//   own divisor N: the output is high for N - floor(N/2) cycles and low for
//   floor(N/2) cycles. New divisors go to a shadow register and are picked up
//   at the next period wrap, so an output never produces a runt pulse.
//
//   Optional feature: define FREQ_DIVIDER_MC_TICK_EN to build the per-channel
//   tick pulse. Without it, tick is tied to zero.
//
// Ports
//   clk      in   clock, everything is clocked on its rising edge
//   rst      in   asynchronous active-high reset
//   enable   in   global count enable (low = all channel state holds)
//   sync     in   restart every channel phase-aligned (wins over enable)
//   div_we   in   divisor write strobe
//   div_ch   in   [3:0] channel addressed by the write
//   div_val  in   [CNTR_WIDTH-1:0] new divisor (full period in clk cycles)
//   clk_out  out  [NUM_CH-1:0] divided clocks, registered
//   tick     out  [NUM_CH-1:0] one-cycle pulse on each wrap-driven rise
//   wr_err   out  one-cycle pulse for a rejected write
// -----------------------------------------------------------------------------
module freq_divider_mc #(
    parameter int NUM_CH      = 4,
    parameter int CNTR_WIDTH  = 8,
    parameter int DEFAULT_DIV = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  sync,
    input  logic                  div_we,
    input  logic [3:0]            div_ch,
    input  logic [CNTR_WIDTH-1:0] div_val,
    output logic [NUM_CH-1:0]     clk_out,
    output logic [NUM_CH-1:0]     tick,
    output logic                  wr_err
);

    localparam logic [CNTR_WIDTH-1:0] DEF_DIV  = CNTR_WIDTH'(DEFAULT_DIV);
    localparam logic [CNTR_WIDTH-1:0] ZERO     = {CNTR_WIDTH{1'b0}};
    localparam logic [CNTR_WIDTH-1:0] ONE      = CNTR_WIDTH'(1);
    localparam logic [CNTR_WIDTH-1:0] TWO      = CNTR_WIDTH'(2);
    localparam logic [4:0]            NUM_CH_W = 5'(NUM_CH);

    // High-phase length N - floor(N/2); stays within CNTR_WIDTH bits for any N.
    function automatic logic [CNTR_WIDTH-1:0] high_len(input logic [CNTR_WIDTH-1:0] n);
        return n - (n >> 1);
    endfunction

    logic [CNTR_WIDTH-1:0] cnt_r [NUM_CH];
    logic [CNTR_WIDTH-1:0] act_r [NUM_CH];
    logic [CNTR_WIDTH-1:0] shd_r [NUM_CH];
    logic [CNTR_WIDTH-1:0] cnt_s [NUM_CH];
    logic [CNTR_WIDTH-1:0] act_s [NUM_CH];
    logic [CNTR_WIDTH-1:0] shd_s [NUM_CH];
    logic [NUM_CH-1:0]     clk_out_r;
    logic [NUM_CH-1:0]     clk_out_s;
    logic [NUM_CH-1:0]     wrap_s;
    logic                  wr_ok_s;
    logic                  wr_bad_s;
    logic                  wr_err_r;

    // Next-state logic for counters, active/shadow divisors and output level.
    always_comb begin
        wr_ok_s  = div_we && ({1'b0, div_ch} < NUM_CH_W) && (div_val >= TWO);
        wr_bad_s = div_we && !wr_ok_s;
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_s[i]     = cnt_r[i];
            act_s[i]     = act_r[i];
            shd_s[i]     = shd_r[i];
            clk_out_s[i] = clk_out_r[i];
            wrap_s[i]    = (cnt_r[i] == (act_r[i] - ONE));
            if (sync) begin
                cnt_s[i]     = ZERO;
                act_s[i]     = shd_r[i];
                clk_out_s[i] = 1'b1;
            end else if (enable) begin
                // The wrap sees the shadow value as it stood before any
                // write landing in this same cycle.
                if (wrap_s[i]) begin
                    cnt_s[i] = ZERO;
                    act_s[i] = shd_r[i];
                end else begin
                    cnt_s[i] = cnt_r[i] + ONE;
                end
                clk_out_s[i] = (cnt_s[i] < high_len(act_s[i]));
            end else begin
                cnt_s[i]     = cnt_r[i];
                act_s[i]     = act_r[i];
                clk_out_s[i] = clk_out_r[i];
            end
            // Writes are accepted regardless of enable/sync.
            if (wr_ok_s && (div_ch == 4'(i))) begin
                shd_s[i] = div_val;
            end else begin
                shd_s[i] = shd_r[i];
            end
        end
    end

    // Channel state registers and the write-error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_r[i] <= ZERO;
                act_r[i] <= DEF_DIV;
                shd_r[i] <= DEF_DIV;
            end
            clk_out_r <= {NUM_CH{1'b1}};
            wr_err_r  <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_r[i] <= cnt_s[i];
                act_r[i] <= act_s[i];
                shd_r[i] <= shd_s[i];
            end
            clk_out_r <= clk_out_s;
            wr_err_r  <= wr_bad_s;
        end
    end

`ifdef FREQ_DIVIDER_MC_TICK_EN
    logic [NUM_CH-1:0] tick_r;
    logic [NUM_CH-1:0] tick_s;

    // Tick fires when a wrap drives the output from low to high.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (sync) begin
                tick_s[i] = 1'b0;
            end else if (enable) begin
                tick_s[i] = wrap_s[i] && !clk_out_r[i];
            end else begin
                tick_s[i] = tick_r[i];
            end
        end
    end

    // Tick register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_r <= {NUM_CH{1'b0}};
        end else begin
            tick_r <= tick_s;
        end
    end

    assign tick = tick_r;
`else
    assign tick = {NUM_CH{1'b0}};
`endif

    assign clk_out = clk_out_r;
    assign wr_err  = wr_err_r;

endmodule

// File: doc/freq_divider_mc.md
FREQ_DIVIDER_MC -- requirements
Module: freq_divider_mc

Interface
REQ-001 Parameter NUM_CH, default 4: number of independent divider channels, range 1..16.
REQ-002 Parameter CNTR_WIDTH, default 8: width of each channel's divisor and counter.
REQ-003 Parameter DEFAULT_DIV, default 10: divisor loaded into every channel at reset; SHALL be in the range 2..2^CNTR_WIDTH-1.
REQ-004 clk  input  1: single clock; all state SHALL be clocked on its rising edge.
REQ-005 rst  input  1: reset, asynchronous, active-high.
REQ-006 enable  input  1: global count enable; when low, all channel state holds.
REQ-007 sync  input  1: one-cycle request to restart every channel phase-aligned.
REQ-008 div_we  input  1: divisor write strobe.
REQ-009 div_ch  input  4: target channel index for the write.
REQ-010 div_val  input  CNTR_WIDTH: new divisor N, where N is the full output period in clk cycles.
REQ-011 clk_out  output  NUM_CH: divided clocks, registered.
REQ-012 tick  output  NUM_CH: one-cycle pulse per channel, registered.
REQ-013 wr_err  output  1: one-cycle pulse flagging a rejected write, registered.

Function
REQ-014 Each channel SHALL hold the following state:
- counter c;
- active divisor d;
- shadow divisor s.
REQ-015 When enable=1 and sync=0, each channel SHALL update per cycle as follows:
- if c==d-1: c<=0 and d<=s;
- otherwise: c<=c+1.
REQ-016 clk_out[i] SHALL be registered as (c_next < H), where H = d_next - floor(d_next/2), and c_next and d_next are the values being loaded this cycle.
- High phase: H cycles.
- Low phase: floor(d/2) cycles.
- Odd N therefore gives one extra high cycle.
REQ-017 tick[i] SHALL be 1 for exactly the cycle in which clk_out[i] transitions 0->1 due to a wrap; it SHALL be 0 otherwise.
REQ-018 When div_we=1, div_ch<NUM_CH and div_val>=2, s[div_ch] SHALL be loaded with div_val; d and c SHALL be unaffected.
REQ-019 When div_we=1 with div_ch>=NUM_CH or div_val<2, no state SHALL change and wr_err SHALL pulse high for 1 cycle on the next edge.
REQ-020 A new divisor SHALL take effect only at the next period wrap, so clk_out SHALL never produce a runt pulse.
- A write in the same cycle as a wrap SHALL NOT be seen by that wrap; the wrap loads the pre-write s, and the new value applies at the following wrap.
REQ-021 When sync=1, in every channel:
- c<=0;
- d<=s;
- clk_out<=1;
- tick<=0.
REQ-022 sync SHALL have priority over enable; sync acts even when enable=0.
REQ-023 When enable=0 and sync=0, c, d, clk_out and tick SHALL hold; divisor writes SHALL still be accepted.
REQ-024 The counter SHALL never exceed d-1; c wraps from d-1 to 0 with no intermediate values.
REQ-025 With N=2^CNTR_WIDTH-1, the arithmetic SHALL not overflow; H SHALL be computed in CNTR_WIDTH bits.

Reset
REQ-026 While rst=1, asynchronously, in every channel:
- c=0;
- d=s=DEFAULT_DIV;
- clk_out=all ones;
- tick=0;
- wr_err=0.
REQ-027 Reset asserted mid-period SHALL abort the period immediately with no output glitch other than the forced high level.
REQ-028 After release, counting SHALL resume on the first rising clk edge with enable=1; the first high phase SHALL last H cycles including the reset-held state.

Configuration
REQ-029 Macro FREQ_DIVIDER_MC_TICK_EN controls the tick feature.
- Defined: tick logic SHALL be built per REQ-017.
- Undefined: tick SHALL be tied to 0 and its registers SHALL be omitted; all other behaviour SHALL be unchanged.

Verification
REQ-030 Reset, enable=1, NUM_CH=4, DEFAULT_DIV=10 -> every clk_out shows 5 high / 5 low cycles repeating; tick pulses every 10 cycles, coincident with each rise.
REQ-031 Write ch1=7 mid-period -> ch1 finishes its current 10-cycle period, then shows 4 high / 3 low; ch0, ch2 and ch3 are unchanged.
REQ-032 Write ch2=2 exactly on a ch2 wrap cycle -> the next ch2 period is 10 cycles, then ch2 shows 1 high / 1 low.
REQ-033 Write div_ch=5 or div_val=1 -> wr_err=1 for 1 cycle; all outputs are unchanged.
REQ-034 Channels at N=6 and N=9, pulse sync -> next cycle all clk_out=1 with c=0; rising edges realign and coincide every 18 cycles.
REQ-035 enable=0 for 20 cycles mid-period, then rst pulse -> outputs frozen during the hold; on rst, clk_out is all ones and tick=0 immediately (asynchronously), and d returns to 10.
